sn74ls166: RTL



---
 rtl/sn74ls166_pkg.sv | 8 +
 rtl/sn74ls166_chk.sv | 49 ++++
 rtl/sn74ls166.sv | 64 ++++++
 3 files changed

// File: rtl/sn74ls166_pkg.sv
// Shared TTL model definitions: register width and the common warning prefix
// used by the board-level usage checkers.
package sn74ls166_pkg;

    localparam int    SR_W            = 8;
    localparam string TTL_WARN_PREFIX = "[TTL WARN]";

endpackage : sn74ls166_pkg

// File: rtl/sn74ls166_chk.sv
// Passive usage checker for the 74LS166 model; compiled only when
// SN74LS166_CHECK_EN is defined. It reports misuse and never drives state.
`ifdef SN74LS166_CHECK_EN
module sn74ls166_chk
    import sn74ls166_pkg::*;
(
    input logic            p7,
    input logic            p9,
    input logic            p6,
    input logic            p15,
    input logic            p1,
    input logic [SR_W-1:0] pdata,
    input logic [SR_W-1:0] sr
);

    time t_clk_rise;
    time t_clr_rise;
    bit  seen_clk;
    bit  seen_clr;

    // On the real part an inhibit edge while CLK is low looks like a clock.
    always @(posedge p6) begin
        if (p7 === 1'b0)
            $display("%s sn74ls166 %m: CLK INH rose while CLK low at %0t (sr=%h)",
                     TTL_WARN_PREFIX, $time, sr);
    end

    always @(posedge p7) begin
        seen_clk   = 1'b1;
        t_clk_rise = $time;
        if (p9 === 1'b1 && ($isunknown(p15) || $isunknown(p6) || $isunknown(p1)))
            $display("%s sn74ls166 %m: X/Z on control/serial input at clock %0t (p15=%b p6=%b p1=%b data=%h)",
                     TTL_WARN_PREFIX, $time, p15, p6, p1, pdata);
        if (seen_clr && t_clr_rise == $time)
            $display("%s sn74ls166 %m: CLR released coincident with clock at %0t",
                     TTL_WARN_PREFIX, $time);
    end

    // Whichever of the two coincident edges is processed second reports it.
    always @(posedge p9) begin
        seen_clr   = 1'b1;
        t_clr_rise = $time;
        if (seen_clk && t_clk_rise == $time)
            $display("%s sn74ls166 %m: CLR released coincident with clock at %0t",
                     TTL_WARN_PREFIX, $time);
    end

endmodule : sn74ls166_chk
`endif

// File: rtl/sn74ls166.sv
// 74LS166 8-bit parallel-in/serial-out shift register, zero-delay model.
// Optional usage checker enabled by defining SN74LS166_CHECK_EN.
module sn74ls166
    import sn74ls166_pkg::*;
(
    input  logic p7,
    input  logic p9,
    input  logic p6,
    input  logic p15,
    input  logic p1,
    input  logic p2,
    input  logic p3,
    input  logic p4,
    input  logic p5,
    input  logic p10,
    input  logic p11,
    input  logic p12,
    input  logic p14,
    output logic p13
);

    logic [SR_W-1:0] sr_reg;
    logic [SR_W-1:0] sr_next;
    logic [SR_W-1:0] pdata;
    logic [SR_W-1:0] shift_in;

    // Stage A is bit 0, stage H is bit 7 and drives QH.
    assign pdata    = {p14, p12, p11, p10, p5, p4, p3, p2};
    assign shift_in = {sr_reg[SR_W-2:0], p1};

    // Per stage: inhibit holds, SH/LD low loads, otherwise take the stage below.
    genvar gi;
    generate
        for (gi = 0; gi < SR_W; gi++) begin : g_stage
            assign sr_next[gi] = p6   ? sr_reg[gi]
                               : !p15 ? pdata[gi]
                               :        shift_in[gi];
        end
    endgenerate

    always_ff @(posedge p7 or negedge p9) begin
        if (!p9)
            sr_reg <= '0;
        else
            sr_reg <= sr_next;
    end

    assign p13 = sr_reg[SR_W-1];

`ifdef SN74LS166_CHECK_EN
    sn74ls166_chk u_chk (
        .p7    (p7),
        .p9    (p9),
        .p6    (p6),
        .p15   (p15),
        .p1    (p1),
        .pdata (pdata),
        .sr    (sr_reg)
    );
`else
    // Checker not built; function is identical.
`endif

endmodule : sn74ls166
